// File: rtl/dcm_reset_seq_if.sv
// Signal bundle between the DCM reset sequencer and its environment.
// master is the sequencer side; slave is the DCM/system side.
interface dcm_reset_seq_if;
  logic       dcm_locked;
  logic       dcm_rst;
  logic       sys_reset;
  logic       cpu_reset;
  logic       ready;
  logic       clk_en;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  modport master (
    input  dcm_locked,
    output dcm_rst,
    output sys_reset,
    output cpu_reset,
    output ready,
    output clk_en,
    output lock_lost,
    output retry_cnt
  );

  modport slave (
    output dcm_locked,
    input  dcm_rst,
    input  sys_reset,
    input  cpu_reset,
    input  ready,
    input  clk_en,
    input  lock_lost,
    input  retry_cnt
  );
endinterface

// File: rtl/dcm_reset_seq.sv
// Resets the DCM, waits for a settled lock, then releases fabric and CPU resets in stages
// and generates a periodic clock-enable. Re-runs the sequence on timeout or lock loss.
module dcm_reset_seq #(
  parameter int unsigned DCM_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 1024,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned CPU_DELAY      = 8,
  parameter int unsigned CE_DIV         = 4
) (
  input  logic              clk,
  input  logic              reset,
  dcm_reset_seq_if.master   bus
);

  // Counters hold edges-already-seen, so a phase ends when the count reaches N-1.
  localparam logic [15:0] DcmRstLast  = 16'(DCM_RST_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CpuLast     = 16'(CPU_DELAY - 1);
  localparam logic [15:0] CeLast      = 16'(CE_DIV - 1);

  typedef enum logic [2:0] {
    StDcmRst,
    StWaitLock,
    StSettle,
    StSysUp,
    StRun
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] ce_cnt_q;
  logic        sync_q;
  logic        locked_s;
  logic        dcm_rst_q;
  logic        sys_reset_q;
  logic        cpu_reset_q;
  logic        ready_q;
  logic        clk_en_q;
  logic        lock_lost_q;
  logic [3:0]  retry_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StDcmRst;
      cnt_q       <= '0;
      ce_cnt_q    <= '0;
      sync_q      <= 1'b0;
      locked_s    <= 1'b0;
      dcm_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      clk_en_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      sync_q   <= bus.dcm_locked;
      locked_s <= sync_q;
      clk_en_q <= 1'b0;
      if ((state_q == StSysUp || state_q == StRun) && !locked_s) begin
        // Lock dropped after fabric release: flag it and restart without counting a retry.
        state_q     <= StDcmRst;
        cnt_q       <= '0;
        lock_lost_q <= 1'b1;
        dcm_rst_q   <= 1'b1;
        sys_reset_q <= 1'b1;
        cpu_reset_q <= 1'b1;
        ready_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StDcmRst: begin
            if (cnt_q == DcmRstLast) begin
              state_q   <= StWaitLock;
              cnt_q     <= '0;
              dcm_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StWaitLock: begin
            if (locked_s) begin
              state_q <= StSettle;
              cnt_q   <= '0;
            end else if (cnt_q == TimeoutLast) begin
              state_q   <= StDcmRst;
              cnt_q     <= '0;
              dcm_rst_q <= 1'b1;
              if (retry_cnt_q != 4'hF) begin
                retry_cnt_q <= retry_cnt_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StSettle: begin
            if (!locked_s) begin
              state_q <= StWaitLock;
              cnt_q   <= '0;
            end else if (cnt_q == SettleLast) begin
              state_q     <= StSysUp;
              cnt_q       <= '0;
              sys_reset_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StSysUp: begin
            if (cnt_q == CpuLast) begin
              state_q     <= StRun;
              cnt_q       <= '0;
              ce_cnt_q    <= '0;
              cpu_reset_q <= 1'b0;
              ready_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StRun: begin
            if (ce_cnt_q == CeLast) begin
              ce_cnt_q <= '0;
              clk_en_q <= 1'b1;
            end else begin
              ce_cnt_q <= ce_cnt_q + 16'd1;
            end
          end
          default: begin
            state_q <= StDcmRst;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.dcm_rst   = dcm_rst_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.ready     = ready_q;
  assign bus.clk_en    = clk_en_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_dcm_reset_seq.sv
// Bench for dcm_reset_seq: phase-based reference model checked every edge, plus
// hand-computed timeline checks for directed scenarios and a randomized lock pattern.
module tb_dcm_reset_seq;
  localparam int DcmRstCycles = 4;
  localparam int LockTimeout  = 1024;
  localparam int SettleCycles = 16;
  localparam int CpuDelay     = 8;
  localparam int CeDiv        = 4;

  logic clk = 1'b0;
  logic reset;
  dcm_reset_seq_if bus ();

  dcm_reset_seq #(
    .DCM_RST_CYCLES(DcmRstCycles),
    .LOCK_TIMEOUT  (LockTimeout),
    .SETTLE_CYCLES (SettleCycles),
    .CPU_DELAY     (CpuDelay),
    .CE_DIV        (CeDiv)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Model: phase 0..4 = dcm reset, wait lock, settle, sys up, run; t0 = edge the phase began.
  bit hist[$];
  int ph, t0, m_retry, e_el;
  bit m_lost, m_ce, ls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    ph = 0; t0 = 0; m_retry = 0; m_lost = 0; m_ce = 0; edge_n = 0;
  endtask

  function automatic logic [9:0] model_vec();
    return {ph == 0, ph < 3, ph < 4, ph == 4, m_ce, m_lost, 4'(m_retry)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.dcm_rst, bus.sys_reset, bus.cpu_reset, bus.ready, bus.clk_en, bus.lock_lost,
            bus.retry_cnt};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      edge_n++;
      // The sequencer sees dcm_locked as it was two edges earlier.
      ls = (edge_n >= 3) ? hist[edge_n - 3] : 1'b0;
      hist.push_back(bus.dcm_locked);
      e_el = edge_n - t0;
      m_ce = 1'b0;
      case (ph)
        0: if (e_el == DcmRstCycles) begin ph = 1; t0 = edge_n; end
        1: begin
          if (ls) begin ph = 2; t0 = edge_n; end
          else if (e_el == LockTimeout) begin
            ph = 0; t0 = edge_n;
            if (m_retry < 15) m_retry++;
          end
        end
        2: begin
          if (!ls) begin ph = 1; t0 = edge_n; end
          else if (e_el == SettleCycles) begin ph = 3; t0 = edge_n; end
        end
        3: begin
          if (!ls) begin ph = 0; t0 = edge_n; m_lost = 1'b1; end
          else if (e_el == CpuDelay) begin ph = 4; t0 = edge_n; end
        end
        4: begin
          if (!ls) begin ph = 0; t0 = edge_n; m_lost = 1'b1; end
          else m_ce = (e_el % CeDiv == 0);
        end
        default: ;
      endcase
      #1;
      check("outputs", 32'(dut_vec()), 32'(model_vec()));
    end
  end

  task automatic run_to(input int k);
    do begin
      @(posedge clk);
      #2;
    end while (edge_n < k);
  endtask

  // Reset asserted between edges; values must change with no clock edge.
  task automatic pulse_reset(input logic lk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    bus.dcm_locked = lk;
    #1;
    check("reset_values", 32'(dut_vec()), 32'(10'b1110000000));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.dcm_locked = 1'b1;
    model_reset();
    #3;
    check("por_values", 32'(dut_vec()), 32'(10'b1110000000));
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Default timeline with lock held high.
    run_to(3);  check("dcm_rst_e3", bus.dcm_rst, 1);
    run_to(4);  check("dcm_rst_e4", bus.dcm_rst, 0);
    run_to(20); check("sys_reset_e20", bus.sys_reset, 1);
    run_to(21); check("sys_reset_e21", bus.sys_reset, 0);
    run_to(28); check("cpu_reset_e28", bus.cpu_reset, 1);
    run_to(29); check("cpu_reset_e29", bus.cpu_reset, 0); check("ready_e29", bus.ready, 1);
    run_to(32); check("clk_en_e32", bus.clk_en, 0);
    run_to(33); check("clk_en_e33", bus.clk_en, 1);
    run_to(34); check("clk_en_e34", bus.clk_en, 0);
    run_to(37); check("clk_en_e37", bus.clk_en, 1);

    // Lock loss in RUN, then re-lock.
    run_to(45); bus.dcm_locked = 1'b0;
    run_to(47); check("ready_e47", bus.ready, 1);
    run_to(48);
    check("loss_vec_e48", 32'(dut_vec()), 32'(10'b1110010000));
    run_to(50); bus.dcm_locked = 1'b1;
    run_to(68); check("relock_sys_e68", bus.sys_reset, 1);
    run_to(69); check("relock_sys_e69", bus.sys_reset, 0);
    run_to(72); check("lock_lost_sticky", bus.lock_lost, 1);

    // Reset mid SYS_UP clears lock_lost immediately.
    pulse_reset(1'b1);

    // Lock glitch during SETTLE restarts the settle count.
    run_to(10); bus.dcm_locked = 1'b0;
    run_to(13); bus.dcm_locked = 1'b1;
    run_to(21); check("glitch_sys_e21", bus.sys_reset, 1);
    run_to(31); check("glitch_sys_e31", bus.sys_reset, 1);
    run_to(32); check("glitch_sys_e32", bus.sys_reset, 0);

    // Lock first seen at edge 100.
    pulse_reset(1'b0);
    run_to(99);  bus.dcm_locked = 1'b1;
    run_to(117); check("late_sys_e117", bus.sys_reset, 1);
    run_to(118); check("late_sys_e118", bus.sys_reset, 0); check("late_retry", bus.retry_cnt, 0);

    // Randomized lock pattern, mostly locked with short dropouts.
    pulse_reset(1'b1);
    for (int s = 0; s < 150; s++) begin
      logic v;
      int len;
      v = ($urandom_range(0, 3) != 0);
      len = v ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 6));
      bus.dcm_locked = v;
      repeat (len) begin
        @(posedge clk);
        #2;
      end
    end

    // Never locks: timeout retries saturate at 15.
    pulse_reset(1'b0);
    run_to(4);    check("nolock_dcm_e4", bus.dcm_rst, 0);
    run_to(1027); check("nolock_retry_e1027", bus.retry_cnt, 0);
    run_to(1028); check("nolock_dcm_e1028", bus.dcm_rst, 1); check("nolock_retry_e1028", bus.retry_cnt, 1);
    run_to(1032); check("nolock_dcm_e1032", bus.dcm_rst, 0);
    run_to(1028 * 16 + 5);
    check("nolock_retry_sat", bus.retry_cnt, 15);
    check("nolock_lost", bus.lock_lost, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
